// File: rtl/wave_pkg.sv
// Shared state encoding and default widths for the waveform analyzer.
package wave_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_CNT_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEEK,
    ST_RISING,
    ST_FALLING
  } state_t;

endpackage

// File: rtl/reversal_detector.sv
// Combinational turning-point test: has the sample moved strictly more than
// hyst away from a running extreme? i_dir=1 looks upward from a minimum, i_dir=0 downward from a maximum.
module reversal_detector
  import wave_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] i_run_extreme,
  input  logic [DATA_W-1:0] i_sample,
  input  logic [DATA_W-1:0] i_hyst,
  input  logic              i_dir,
  output logic              o_hit
);

  logic [DATA_W:0] w_ext;
  logic [DATA_W:0] w_smp;
  logic [DATA_W:0] w_hyst;
  logic [DATA_W:0] w_lhs;
  logic [DATA_W:0] w_rhs;

  assign w_ext  = {1'b0, i_run_extreme};
  assign w_smp  = {1'b0, i_sample};
  assign w_hyst = {1'b0, i_hyst};

  // Move the hysteresis to the side of the addition so nothing underflows,
  // and the extra bit keeps extreme+hyst from wrapping.
  always_comb begin
    // NOTE: default every combinational output first so no path infers a latch.
    w_lhs = w_ext;
    w_rhs = w_smp + w_hyst;
    if (i_dir) begin
      w_lhs = w_smp;
      w_rhs = w_ext + w_hyst;
    end
  end

  assign o_hit = (w_lhs > w_rhs);

endmodule

// File: rtl/waveform_analyzer.sv
// Measures peak, trough and period of a periodic unsigned sample stream using hysteretic
// turning-point detection. Optional watchdog with `define WAVE_ANALYZER_TIMEOUT_EN.
module waveform_analyzer
  import wave_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
`ifdef WAVE_ANALYZER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1_000_000
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] hysteresis,
  output logic [DATA_W-1:0] peak,
  output logic [DATA_W-1:0] trough,
  output logic [CNT_W-1:0]  period,
  output logic              meas_valid,
`ifdef WAVE_ANALYZER_TIMEOUT_EN
  output logic              timeout,
`endif
  output logic              locked
);

  state_t            r_state;
  logic [DATA_W-1:0] r_run_max;
  logic [DATA_W-1:0] r_run_min;
  logic [DATA_W-1:0] r_cand_trough;
  logic [DATA_W-1:0] r_peak;
  logic [DATA_W-1:0] r_trough;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_period;
  logic              r_have_peak;
  logic              r_meas_valid;
  logic              r_locked;

  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_up_hit;
  logic              w_down_hit;
  logic              w_peak_hit;
  logic              w_trough_hit;

  reversal_detector #(.DATA_W(DATA_W)) u_up (
    .i_run_extreme (r_run_min),
    .i_sample      (sample),
    .i_hyst        (hysteresis),
    .i_dir         (1'b1),
    .o_hit         (w_up_hit)
  );

  reversal_detector #(.DATA_W(DATA_W)) u_down (
    .i_run_extreme (r_run_max),
    .i_sample      (sample),
    .i_hyst        (hysteresis),
    .i_dir         (1'b0),
    .o_hit         (w_down_hit)
  );

  assign w_cnt_next   = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_peak_hit   = sample_valid && (r_state == ST_RISING)  && w_down_hit;
  assign w_trough_hit = sample_valid && (r_state == ST_FALLING) && w_up_hit;

`ifdef WAVE_ANALYZER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] r_wd;
  logic            r_timeout;
  logic            w_turn;

  assign w_turn  = w_peak_hit || w_trough_hit ||
                   (sample_valid && (r_state == ST_SEEK) && (w_up_hit || w_down_hit));
  assign timeout = r_timeout;
`endif

  always_ff @(posedge clk) begin
    // NOTE: all state uses non-blocking assignments; the pulse defaults below are overridden later in the block.
    r_meas_valid <= 1'b0;
`ifdef WAVE_ANALYZER_TIMEOUT_EN
    r_timeout    <= 1'b0;
`endif
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_run_max     <= '0;
      r_run_min     <= '0;
      r_cand_trough <= '0;
      r_peak        <= '0;
      r_trough      <= '0;
      r_period      <= '0;
      r_cnt         <= '0;
      r_have_peak   <= 1'b0;
      r_locked      <= 1'b0;
`ifdef WAVE_ANALYZER_TIMEOUT_EN
      r_wd          <= '0;
`endif
    end else if (!ena) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_have_peak <= 1'b0;
      r_locked    <= 1'b0;
`ifdef WAVE_ANALYZER_TIMEOUT_EN
      r_wd        <= '0;
`endif
    end else begin
      r_cnt <= (r_state == ST_IDLE) ? '0 : w_cnt_next;

      if (sample_valid) begin
        case (r_state)
          ST_IDLE: begin
            r_run_max <= sample;
            r_run_min <= sample;
            r_state   <= ST_SEEK;
          end
          ST_SEEK: begin
            if (w_up_hit) begin
              r_run_max <= sample;
              r_state   <= ST_RISING;
            end else if (w_down_hit) begin
              r_run_min <= sample;
              r_state   <= ST_FALLING;
            end else begin
              if (sample > r_run_max) r_run_max <= sample;
              if (sample < r_run_min) r_run_min <= sample;
            end
          end
          ST_RISING: begin
            if (w_down_hit) begin
              // r_cnt holds the clocks since the previous peak, counting this one;
              // restarting at 1 keeps every period measured edge-to-edge.
              r_run_min   <= sample;
              r_state     <= ST_FALLING;
              r_cnt       <= CNT_W'(1);
              r_have_peak <= 1'b1;
              if (r_have_peak) begin
                r_peak       <= r_run_max;
                r_trough     <= r_cand_trough;
                r_period     <= r_cnt;
                r_meas_valid <= 1'b1;
                r_locked     <= 1'b1;
              end
            end else if (sample > r_run_max) begin
              r_run_max <= sample;
            end
          end
          ST_FALLING: begin
            if (w_up_hit) begin
              r_cand_trough <= r_run_min;
              r_run_max     <= sample;
              r_state       <= ST_RISING;
            end else if (sample < r_run_min) begin
              r_run_min <= sample;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end

`ifdef WAVE_ANALYZER_TIMEOUT_EN
      // Watchdog overrides the FSM update above; held results stay untouched.
      if ((r_state == ST_IDLE) || w_turn) begin
        r_wd <= '0;
      end else if (r_wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
        r_wd        <= '0;
        r_timeout   <= 1'b1;
        r_locked    <= 1'b0;
        r_have_peak <= 1'b0;
        r_state     <= ST_IDLE;
      end else begin
        r_wd <= r_wd + WD_W'(1);
      end
`endif
    end
  end

  assign peak       = r_peak;
  assign trough     = r_trough;
  assign period     = r_period;
  assign meas_valid = r_meas_valid;
  assign locked     = r_locked;

endmodule

// File: tb/tb_waveform_analyzer.sv
// Self-checking bench for waveform_analyzer: triangle sources built from plain arithmetic,
// expected peak/trough/period derived from the source parameters.
module tb_waveform_analyzer;

  localparam int DATA_W  = 16;
  localparam int CNT_W   = 10;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ena;
  logic              sample_valid;
  logic [DATA_W-1:0] sample;
  logic [DATA_W-1:0] hysteresis;
  logic [DATA_W-1:0] peak;
  logic [DATA_W-1:0] trough;
  logic [CNT_W-1:0]  period;
  logic              meas_valid;
  logic              locked;
`ifdef WAVE_ANALYZER_TIMEOUT_EN
  logic              timeout;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int m_peak, m_trough, m_period;

  waveform_analyzer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .sample_valid (sample_valid),
    .sample       (sample),
    .hysteresis   (hysteresis),
    .peak         (peak),
    .trough       (trough),
    .period       (period),
    .meas_valid   (meas_valid),
`ifdef WAVE_ANALYZER_TIMEOUT_EN
    .timeout      (timeout),
`endif
    .locked       (locked)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input logic [63:0] obs,
                             input logic [63:0] lo, input logic [63:0] hi);
    n_checks++;
    assert (obs >= lo && obs <= hi) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Ideal triangle: base..base+amp..base, each level held for pre+1 valid samples.
  function automatic int tri_val(input int base, input int amp, input int pre, input int s);
    int ph;
    ph = (s / (pre + 1)) % (2 * amp);
    return base + ((ph <= amp) ? ph : 2 * amp - ph);
  endfunction

  task automatic ena_cycle();
    ena          = 1'b0;
    sample_valid = 1'b0;
    tick();
    tick();
    ena = 1'b1;
  endtask

  // Drive ncyc full source periods (plus extra clocks); div=2 presents a valid sample every other clock.
  task automatic run_triangle(input string tag, input int base, input int amp, input int pre,
                              input int hyst, input int div, input int ncyc, input int extra,
                              input bit noise);
    int p, total, s, v, pulses, last;
    p      = 2 * amp * (pre + 1) * div;
    total  = ncyc * p + extra;
    s      = 0;
    pulses = 0;
    last   = -1;
    hysteresis = DATA_W'(hyst);
    for (int k = 0; k < total; k++) begin
      if (k % div == 0) begin
        v = tri_val(base, amp, pre, s);
        if (noise) v = v + int'($urandom_range(0, 4)) - 2;
        if (v < 0) v = 0;
        sample       = DATA_W'(v);
        sample_valid = 1'b1;
        s++;
      end else begin
        sample       = DATA_W'($urandom);
        sample_valid = 1'b0;
      end
      tick();
      if (k == 0) check({tag, " locked before lock"}, locked, 0);
      if (meas_valid) begin
        pulses++;
        check({tag, " locked"}, locked, 1);
        if (!noise) begin
          check({tag, " peak"}, peak, base + amp);
          check({tag, " trough"}, trough, base);
          check({tag, " period"}, period, (p > CNT_MAX) ? CNT_MAX : p);
        end else begin
          check_range({tag, " peak"}, peak, base + amp - 2, base + amp + 2);
          check_range({tag, " trough"}, trough, base, base + 2);
          check_range({tag, " period"}, period, p - 15, p + 15);
        end
        if (last < 0)
          check_range({tag, " first pulse clk"}, k, p, 2 * p - 1);
        else if (!noise)
          check({tag, " pulse spacing"}, k - last, p);
        else
          check_range({tag, " pulse spacing"}, k - last, p - 15, p + 15);
        last = k;
      end
    end
    check({tag, " pulse count"}, pulses, ncyc - 1);
    if (!noise && ncyc >= 2) begin
      m_peak   = base + amp;
      m_trough = base;
      m_period = (p > CNT_MAX) ? CNT_MAX : p;
    end
  endtask

  initial begin
    int base, amp, pre, hy, dv, pulses;
    rst_n        = 1'b0;
    ena          = 1'b0;
    sample_valid = 1'b0;
    sample       = '0;
    hysteresis   = '0;
    tick();
    tick();
    check("reset peak", peak, 0);
    check("reset trough", trough, 0);
    check("reset period", period, 0);
    check("reset meas_valid", meas_valid, 0);
    check("reset locked", locked, 0);
    rst_n = 1'b1;
    ena   = 1'b1;

    run_triangle("tri_basic", 0, 10, 0, 0, 1, 4, 0, 1'b0);
    ena_cycle();
    run_triangle("tri_presc", 0, 10, 3, 0, 1, 3, 0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      base = int'($urandom_range(0, 1000));
      amp  = int'($urandom_range(4, 30));
      pre  = int'($urandom_range(0, 3));
      hy   = int'($urandom_range(0, amp / 2));
      dv   = int'($urandom_range(1, 2));
      ena_cycle();
      run_triangle($sformatf("tri_rand%0d", i), base, amp, pre, hy, dv, 3, 0, 1'b0);
    end

    ena_cycle();
    run_triangle("tri_noise", 0, 100, 0, 4, 1, 5, 0, 1'b1);

    // Flat input: no reversal, so never a measurement.
    ena_cycle();
    hysteresis = '0;
    pulses     = 0;
    for (int k = 0; k < 10000; k++) begin
      sample       = 16'h1234;
      sample_valid = 1'b1;
      tick();
      if (meas_valid) pulses++;
    end
    check("flat pulses", pulses, 0);
    check("flat locked", locked, 0);

    // Period longer than the counter range reports the saturated value.
    ena_cycle();
    run_triangle("tri_sat", 0, 10, 59, 0, 1, 3, 0, 1'b0);

    // Drop ena mid-ramp after lock: lock clears, results hold.
    ena_cycle();
    run_triangle("tri_pre_abort", 20, 12, 1, 2, 1, 3, 12, 1'b0);
    ena          = 1'b0;
    sample_valid = 1'b0;
    tick();
    check("abort locked", locked, 0);
    check("abort meas_valid", meas_valid, 0);
    check("abort peak hold", peak, m_peak);
    check("abort trough hold", trough, m_trough);
    check("abort period hold", period, m_period);
    tick();
    ena = 1'b1;
    run_triangle("tri_reenable", 20, 12, 1, 2, 1, 3, 0, 1'b0);

    // One-clock reset in the middle of a measurement, then recovery.
    ena_cycle();
    run_triangle("tri_pre_reset", 0, 10, 0, 0, 1, 3, 5, 1'b0);
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midreset peak", peak, 0);
    check("midreset trough", trough, 0);
    check("midreset period", period, 0);
    check("midreset meas_valid", meas_valid, 0);
    check("midreset locked", locked, 0);
    run_triangle("tri_recover", 0, 10, 0, 0, 1, 4, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
